mem_access: RTL and testbench

Memory-access stage of the five-stage RISC-V core. It consumes the EX/MEM pipeline register outputs, performs word loads and stores over a req/gnt/rvalid data-memory bus, and stalls the upstream pipeline while a transaction is outstanding. It resolves the branch decision for the fetch stage and registers the MEM/WB payload for write-back.

---
 rtl/mem_access_pkg.sv | 27 ++
 rtl/mem_wb_reg.sv | 21 ++
 rtl/mem_access.sv | 156 +++++++++++++++
 tb/tb_mem_access.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage: data widths,
// FSM state encoding and the MEM/WB payload layout.
package mem_access_pkg;

  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic FUN_DISABLE = 1'b0;
  localparam int MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0] mem_rdata;
    logic [INST_WIDTH-1:0] alu_result;
    logic [4:0]            reg_waddr;
    logic                  mem2reg;
    logic                  reg_wena;
    logic                  misalign;
    logic                  bus_err;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the write-back payload when load is high,
// otherwise holds; clears asynchronously on reset.
module mem_wb_reg
  import mem_access_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: word loads/stores over a req/gnt/rvalid bus with an
// abort timer, upstream stall generation, branch resolution and MEM/WB update.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_WIDTH-1:0] pcWithImm,
  input  logic                  zero,
  input  logic [INST_WIDTH-1:0] alu_result,
  input  logic                  branch,
  input  logic                  mem_rena,
  input  logic                  mem_wena,
  input  logic                  mem2reg,
  input  logic                  reg_wena,
  input  logic [INST_WIDTH-1:0] reg2_data,
  input  logic [4:0]            reg_waddr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [INST_WIDTH-1:0] dmem_addr,
  output logic [INST_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [INST_WIDTH-1:0] dmem_rdata,
  output logic                  stall,
  output logic                  pc_src,
  output logic [INST_WIDTH-1:0] pc_target,
  output logic [INST_WIDTH-1:0] mem_rdata_o,
  output logic [INST_WIDTH-1:0] alu_result_o,
  output logic                  mem2reg_o,
  output logic                  reg_wena_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic [4:0]            reg_waddr_o,
  output mem_state_e            dbg_state
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  mem_state_e            state, state_nxt;
  logic [7:0]            cnt;
  logic [INST_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic                  we_q, err_q;
  logic                  access, misaligned, start, tmo_hit, abort;
  logic                  in_done, wb_load;
  mem_wb_t               wb_d, wb_q;

  assign access     = mem_rena | mem_wena;
  assign misaligned = (alu_result[1:0] != 2'b00);
  assign start      = access & ~misaligned;
  assign tmo_hit    = (cnt == TMO_LAST);

  // Bus handshake: dmem_req stays high in REQ until dmem_gnt; dmem_rvalid is only
  // honoured in WAIT. A response arriving on the timeout cycle still wins.
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        if (dmem_gnt) begin
          state_nxt = we_q ? ST_DONE : ST_WAIT;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          abort     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_nxt = ST_DONE;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
          abort     = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      addr_q  <= ZERO_WORD;
      wdata_q <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
      we_q    <= FUN_DISABLE;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= {alu_result[INST_WIDTH-1:2], 2'b00};
            wdata_q <= reg2_data;
            we_q    <= mem_wena;
            rdata_q <= ZERO_WORD;
            err_q   <= 1'b0;
            cnt     <= 8'd0;
          end
        end
        ST_REQ, ST_WAIT: begin
          cnt <= cnt + 8'd1;
          if (abort) err_q <= 1'b1;
          if (state == ST_WAIT && dmem_rvalid) rdata_q <= dmem_rdata;
        end
        ST_DONE: we_q <= FUN_DISABLE;
        default: ;
      endcase
    end
  end

  assign dmem_req   = (state == ST_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign stall      = (state == ST_REQ) | (state == ST_WAIT) | ((state == ST_IDLE) & start);
  assign pc_src     = branch & zero & (state == ST_IDLE);
  assign pc_target  = pcWithImm;
  assign dbg_state  = state;

  // EX/MEM is held for the whole transaction, so its fields are still valid in DONE.
  assign in_done = (state == ST_DONE);
  assign wb_load = ((state == ST_IDLE) & ~start) | in_done;

  always_comb begin
    wb_d            = '0;
    wb_d.mem_rdata  = (in_done & ~err_q) ? rdata_q : ZERO_WORD;
    wb_d.alu_result = alu_result;
    wb_d.reg_waddr  = reg_waddr;
    wb_d.mem2reg    = mem2reg;
    wb_d.misalign   = ~in_done & access & misaligned;
    wb_d.bus_err    = in_done & err_q;
    wb_d.reg_wena   = reg_wena & ~wb_d.misalign & ~wb_d.bus_err;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk  (clk),
    .rst  (rst),
    .load (wb_load),
    .d    (wb_d),
    .q    (wb_q)
  );

  assign mem_rdata_o  = wb_q.mem_rdata;
  assign alu_result_o = wb_q.alu_result;
  assign reg_waddr_o  = wb_q.reg_waddr;
  assign mem2reg_o    = wb_q.mem2reg;
  assign reg_wena_o   = wb_q.reg_wena;
  assign misalign_o   = wb_q.misalign;
  assign bus_err_o    = wb_q.bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, load/store handshakes,
// misalignment, bus timeout, async reset mid-transaction and branch resolution.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk, rst;
  logic [31:0] pcWithImm, alu_result, reg2_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_target, mem_rdata_o, alu_result_o;
  logic        zero, branch, mem_rena, mem_wena, mem2reg, reg_wena;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall, pc_src;
  logic        mem2reg_o, reg_wena_o, misalign_o, bus_err_o;
  logic [4:0]  reg_waddr, reg_waddr_o;
  mem_state_e  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pcWithImm(pcWithImm), .zero(zero), .alu_result(alu_result),
    .branch(branch), .mem_rena(mem_rena), .mem_wena(mem_wena), .mem2reg(mem2reg),
    .reg_wena(reg_wena), .reg2_data(reg2_data), .reg_waddr(reg_waddr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target), .mem_rdata_o(mem_rdata_o),
    .alu_result_o(alu_result_o), .mem2reg_o(mem2reg_o), .reg_wena_o(reg_wena_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .reg_waddr_o(reg_waddr_o),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got running, expected done)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_instr(input logic rena, input logic wena, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic rwena, input logic m2r,
                           input logic [4:0] rd);
    mem_rena   = rena;
    mem_wena   = wena;
    alu_result = addr;
    reg2_data  = wdata;
    reg_wena   = rwena;
    mem2reg    = m2r;
    reg_waddr  = rd;
  endtask

  task automatic clear_instr();
    set_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
  endtask

  // Called at a negedge right after set_instr; returns #1 after the DONE edge.
  task automatic run_mem(input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                         input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata,
                         output int n_stall, output int n_req, output logic bus_ok);
    int   wait_seen;
    logic done;
    n_stall = 0; n_req = 0; bus_ok = 1'b1; wait_seen = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stall) n_stall++;
      if (dmem_req) begin
        if (dmem_we !== exp_we || dmem_addr !== exp_addr ||
            (exp_we && dmem_wdata !== exp_wdata)) bus_ok = 1'b0;
        dmem_gnt = (n_req >= gnt_dly);
        n_req++;
      end
      if (dbg_state == ST_WAIT) begin
        dmem_rvalid = (wait_seen >= rv_dly);
        dmem_rdata  = dmem_rvalid ? rd : 32'h0BAD_0BAD;
        wait_seen++;
      end
      if (dbg_state == ST_DONE) done = 1'b1;
      @(posedge clk);
      #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (!done) @(negedge clk);
    end
    chk("txn_done", {31'b0, done}, 32'd1);
    clear_instr();
  endtask

  int   n_stall, n_req;
  logic bus_ok;

  initial begin
    rst = 1'b0;
    pcWithImm = '0; zero = 1'b0; branch = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    clear_instr();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_alu_o", alu_result_o, 32'd0);
    chk("rst_rdata_o", mem_rdata_o, 32'd0);
    chk("rst_flags", {28'b0, reg_wena_o, mem2reg_o, misalign_o, bus_err_o}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // ALU op: single-cycle pass-through
    @(negedge clk);
    set_instr(1'b0, 1'b0, 32'h1234, 32'h0, 1'b1, 1'b0, 5'd5);
    #1 chk("alu_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("alu_stall_post", {31'b0, stall}, 32'd0);
    chk("alu_result_o", alu_result_o, 32'h1234);
    chk("alu_wena_waddr", {26'b0, reg_wena_o, reg_waddr_o}, {26'b0, 1'b1, 5'd5});
    clear_instr();

    // load 0x40, immediate gnt, rvalid next cycle
    @(negedge clk);
    set_instr(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 5'd7);
    exp_q.push_back(32'hDEADBEEF);
    run_mem(0, 0, 32'hDEADBEEF, 1'b0, 32'h40, 32'h0, n_stall, n_req, bus_ok);
    chk("ld_stall", n_stall, 32'd3);
    chk("ld_req", n_req, 32'd1);
    chk("ld_bus", {31'b0, bus_ok}, 32'd1);
    chk("ld_rdata", mem_rdata_o, exp_q.pop_front());
    chk("ld_flags", {26'b0, reg_wena_o, mem2reg_o, misalign_o, bus_err_o, 2'b0},
        {26'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b0});
    chk("ld_waddr", {27'b0, reg_waddr_o}, 32'd7);

    // store 0x80, gnt after 2 wait cycles
    @(negedge clk);
    set_instr(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd0);
    exp_q.push_back(32'h0);
    run_mem(2, 0, 32'h0, 1'b1, 32'h80, 32'hA5A5A5A5, n_stall, n_req, bus_ok);
    chk("st_stall", n_stall, 32'd4);
    chk("st_req", n_req, 32'd3);
    chk("st_bus_stable", {31'b0, bus_ok}, 32'd1);
    chk("st_rdata", mem_rdata_o, exp_q.pop_front());
    chk("st_alu_o", alu_result_o, 32'h80);

    // misaligned load
    @(negedge clk);
    set_instr(1'b1, 1'b0, 32'h42, 32'h0, 1'b1, 1'b1, 5'd3);
    #1;
    chk("mis_stall", {31'b0, stall}, 32'd0);
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    chk("mis_flags", {29'b0, misalign_o, reg_wena_o, dmem_req}, {29'b0, 1'b1, 1'b0, 1'b0});
    chk("mis_state", 32'(dbg_state), 32'(ST_IDLE));
    clear_instr();

    // timeout: gnt never arrives
    @(negedge clk);
    set_instr(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd4);
    exp_q.push_back(32'h0);
    run_mem(99, 0, 32'h0, 1'b0, 32'h100, 32'h0, n_stall, n_req, bus_ok);
    chk("tmo_req", n_req, 32'd4);
    chk("tmo_stall", n_stall, 32'd5);
    chk("tmo_flags", {29'b0, bus_err_o, reg_wena_o, misalign_o}, {29'b0, 1'b1, 1'b0, 1'b0});
    chk("tmo_rdata", mem_rdata_o, exp_q.pop_front());
    chk("tmo_state", 32'(dbg_state), 32'(ST_IDLE));

    // next load clears bus_err_o; rvalid delayed one cycle
    @(negedge clk);
    set_instr(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b1, 5'd9);
    exp_q.push_back(32'h13579BDF);
    run_mem(0, 1, 32'h13579BDF, 1'b0, 32'h44, 32'h0, n_stall, n_req, bus_ok);
    chk("ld2_stall", n_stall, 32'd4);
    chk("ld2_rdata", mem_rdata_o, exp_q.pop_front());
    chk("ld2_flags", {30'b0, bus_err_o, reg_wena_o}, {30'b0, 1'b0, 1'b1});

    // async reset while in WAIT; branch suppressed while busy
    @(negedge clk);
    set_instr(1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b1, 5'd10);
    @(negedge clk); #1;
    dmem_gnt = dmem_req;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    branch = 1'b1; zero = 1'b1; pcWithImm = 32'h200;
    #1;
    chk("wait_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("busy_pc_src", {31'b0, pc_src}, 32'd0);
    branch = 1'b0; zero = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'b0, dmem_req}, 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("arst_rdata", mem_rdata_o, 32'd0);
    chk("arst_alu", alu_result_o, 32'd0);
    chk("arst_flags", {26'b0, reg_wena_o, mem2reg_o, misalign_o, bus_err_o, dmem_we, 1'b0}, 32'd0);
    clear_instr();
    @(negedge clk);
    rst = 1'b1;

    // branch resolution in IDLE
    @(negedge clk);
    branch = 1'b1; zero = 1'b1; pcWithImm = 32'h100;
    #1;
    chk("br_taken", {31'b0, pc_src}, 32'd1);
    chk("br_target", pc_target, 32'h100);
    zero = 1'b0;
    #1;
    chk("br_not_taken", {31'b0, pc_src}, 32'd0);
    branch = 1'b0;

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
